// File: rtl/button_conditioner.sv
// Four-button front end: synchronizes and debounces raw push-button levels, then
// emits a single one-hot press pulse and locks out further presses until every button is released.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       level_q, level_d;
  logic [3:0]       level_prev_q, level_prev_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  state_t           state_q, state_d;
  logic [3:0]       pulse_q, pulse_d;
  logic             busy_q, busy_d;

  logic [3:0]       rise;
  logic [3:0]       rise_low;

  // Synchronizer and per-bit debounce counters; the level flips on the cycle the
  // counter would reach DEBOUNCE_CYCLES, so the counter itself never holds that value.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    level_prev_d = level_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign rise     = level_q & ~level_prev_q;
  assign rise_low = rise & (~rise + 4'd1);

  always_comb begin
    state_d = state_q;
    pulse_d = 4'b0000;
    case (state_q)
      IDLE: begin
        if (|rise) begin
          state_d = PULSE;
          pulse_d = rise_low;
        end
      end
      PULSE: state_d = HOLD;
      HOLD: begin
        if (level_q == 4'b0000) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      state_q      <= IDLE;
      pulse_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign busy      = busy_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-002 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles a button must hold before its debounced level changes; legal range is >= 2.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 btn_raw  input  4  raw, asynchronous, bouncing push-button levels; 1 = pressed.
REQ-006 btn_level  output  4  registered, debounced level for each button.
REQ-007 btn_pulse  output  4  registered one-hot press event, high for exactly one cycle; this is the downstream 4-to-2 encoder input.
REQ-008 busy  output  1  registered; high while a press is being emitted or the block is waiting for release.

Function
REQ-009 Each btn_raw bit SHALL pass through its own 2-flip-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Each bit SHALL have its own counter, ceil(log2(DEBOUNCE_CYCLES+1)) bits wide, with the following rules:
- When sync2 equals btn_level, the counter SHALL clear to 0.
- When sync2 differs from btn_level, the counter SHALL increment by 1.
- On the edge where the counter would reach DEBOUNCE_CYCLES, btn_level SHALL toggle and the counter SHALL clear.
REQ-011 Debounce latency: if sync1 first samples a new stable raw value at edge E, btn_level SHALL change at edge E+DEBOUNCE_CYCLES+1.
REQ-012 Any raw change lasting fewer cycles than required by REQ-011 SHALL leave btn_level unchanged, and that bit's counter SHALL return to 0.
REQ-013 Counters SHALL never wrap; the maximum value a counter holds is DEBOUNCE_CYCLES-1.
REQ-014 A rising edge of a bit SHALL be detected as btn_level & ~level_d, where level_d is btn_level delayed by one register.
REQ-015 The press FSM SHALL have three states, IDLE, PULSE and HOLD:
- IDLE -> PULSE when any rising edge is detected; the lowest-index rising bit SHALL be captured.
- PULSE -> HOLD unconditionally after one cycle.
- HOLD -> IDLE on the first edge at which btn_level == 4'b0000.
REQ-016 btn_pulse SHALL equal the captured one-hot value while the FSM is in PULSE, and 4'b0000 in every other state.
REQ-017 Pulse latency: a btn_level rise at edge L SHALL produce btn_pulse high from edge L+1 to edge L+2.
REQ-018 If several rising edges occur in the same cycle, only the lowest index SHALL be emitted; the other edges SHALL be discarded, not queued.
REQ-019 Rising edges that occur in the PULSE or HOLD state SHALL be ignored.
REQ-020 busy SHALL be 1 in PULSE and HOLD and 0 in IDLE.
REQ-021 btn_pulse SHALL never have more than one bit set.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for a clock edge, clear all of the following to 0: sync1, sync2, level_d, all counters, btn_level, btn_pulse and busy, and force the FSM to IDLE.
REQ-023 A button held through reset release SHALL be treated as a new press: it debounces per REQ-011 and produces one pulse.
REQ-024 Reset asserted mid-debounce or in PULSE/HOLD SHALL abort the operation; no partial pulse SHALL appear after reset release.

Verification (all scenarios use DEBOUNCE_CYCLES=4)
REQ-025 Reset: rst=1 with btn_raw=4'b0101 -> btn_level, btn_pulse and busy all 0 immediately and throughout reset, without a clock edge.
REQ-026 Clean press: btn_raw[2] goes 0->1 and is held for 20 cycles; sampled at edge E -> btn_level=4'b0100 at E+5, btn_pulse=4'b0100 for exactly the cycle E+6..E+7, busy=1 from E+6.
REQ-027 Glitch: btn_raw[1] high for 3 cycles, then 0 -> btn_level and btn_pulse stay 0.
REQ-028 Simultaneous press: btn_raw[3] and btn_raw[1] rise in the same cycle -> a single pulse 4'b0010; no pulse ever appears for bit 3; busy stays 1 until both buttons are released and debounced.
REQ-029 Lockout: while btn0 is held (HOLD state), btn3 is pressed -> no pulse; after all buttons are released and debounced, pressing btn0 -> btn_pulse=4'b0001 once.
REQ-030 Reset mid-operation: rst pulses high in HOLD with btn_raw=0 -> outputs go to 0 immediately; a subsequent btn2 press yields btn_pulse=4'b0100 with the latency of REQ-026.
